// File: rtl/custom_mode_pkg.sv
// Shared definitions for the custom-mode result path: FSM encoding and
// result-slot indices used by the result writer.
package custom_mode_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int NUM_RESULTS = 4;

   localparam logic [1:0] IDX_C11 = 2'd0;
   localparam logic [1:0] IDX_C12 = 2'd1;
   localparam logic [1:0] IDX_C21 = 2'd2;
   localparam logic [1:0] IDX_C22 = 2'd3;

endpackage : custom_mode_pkg

// File: rtl/custom_result_writer.sv
// Captures the four 2x2 custom-mode results on the rising edge of the engine's
// done level and streams them to the result memory over valid/ready.
module custom_result_writer
   import custom_mode_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              custom_mode_done,
   input  logic [DATA_W-1:0] c11_custom,
   input  logic [DATA_W-1:0] c12_custom,
   input  logic [DATA_W-1:0] c21_custom,
   input  logic [DATA_W-1:0] c22_custom,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              write_done
);

   state_e            state_q, state_d;
   logic              done_q;
   logic [1:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] r_q [NUM_RESULTS];
   logic [DATA_W-1:0] r_d [NUM_RESULTS];
   logic              capture;

   // done_q resets high so a done level held through reset is not an edge
   assign capture = custom_mode_done && !done_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      for (int i = 0; i < NUM_RESULTS; i++) begin
         r_d[i] = r_q[i];
      end

      case (state_q)
         ST_IDLE: begin
            if (capture) begin
               state_d      = ST_WRITE;
               r_d[IDX_C11] = c11_custom;
               r_d[IDX_C12] = c12_custom;
               r_d[IDX_C21] = c21_custom;
               r_d[IDX_C22] = c22_custom;
               base_d       = base_addr;
               idx_d        = IDX_C11;
            end
         end
         ST_WRITE: begin
            if (mem_ready) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == IDX_C22) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (!custom_mode_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b1;
         idx_q   <= '0;
         base_q  <= '0;
         for (int i = 0; i < NUM_RESULTS; i++) begin
            r_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         done_q  <= custom_mode_done;
         idx_q   <= idx_d;
         base_q  <= base_d;
         for (int i = 0; i < NUM_RESULTS; i++) begin
            r_q[i] <= r_d[i];
         end
      end
   end

   // Outputs decode registered state only; address wraps modulo 2^ADDR_W
   assign mem_wr_en  = (state_q == ST_WRITE);
   assign busy       = (state_q == ST_WRITE);
   assign write_done = (state_q == ST_DONE);
   assign mem_addr   = mem_wr_en ? (base_q + ADDR_W'(idx_q)) : '0;
   assign mem_wdata  = mem_wr_en ? r_q[idx_q] : '0;

endmodule : custom_result_writer

// File: tb/tb_custom_result_writer.sv
// Directed bench for custom_result_writer with a write scoreboard.
module tb_custom_result_writer;

   logic       clk;
   logic       rst;
   logic       cmd;
   logic [7:0] c11, c12, c21, c22;
   logic [7:0] base_addr;
   logic       mem_wr_en;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_ready;
   logic       busy;
   logic       write_done;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   custom_result_writer #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .custom_mode_done (cmd),
      .c11_custom       (c11),
      .c12_custom       (c12),
      .c21_custom       (c21),
      .c22_custom       (c22),
      .base_addr        (base_addr),
      .mem_wr_en        (mem_wr_en),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_ready        (mem_ready),
      .busy             (busy),
      .write_done       (write_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic capture(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          input logic [7:0] base);
      exp_t e;
      c11 = a; c12 = b; c21 = c; c22 = d;
      base_addr = base;
      cmd = 1'b1;
      e.addr = base;         e.data = a; sb.push_back(e);
      e.addr = base + 8'd1;  e.data = b; sb.push_back(e);
      e.addr = base + 8'd2;  e.data = c; sb.push_back(e);
      e.addr = base + 8'd3;  e.data = d; sb.push_back(e);
      @(posedge clk); #1;
   endtask

   // Runs one write burst from the cycle after capture until write_done.
   task automatic run_write(input int stall_at, input int stall_n,
                            input bit scramble, input int exp_lat);
      int   lat    = 0;
      int   word   = 0;
      int   stalls = 0;
      bit   seen   = 1'b0;
      exp_t e;
      for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
         mem_ready = !(word == stall_at && stalls < stall_n);
         if (scramble) begin
            c11 = 8'($urandom); c12 = 8'($urandom);
            c21 = 8'($urandom); c22 = 8'($urandom);
            base_addr = 8'($urandom);
         end
         @(negedge clk);
         lat++;
         if (write_done) begin
            seen = 1'b1;
            chk("done_latency", lat, exp_lat);
            chk("done_busy", busy, 1'b0);
            chk("done_wr_en", mem_wr_en, 1'b0);
            chk("sb_empty", sb.size(), 0);
         end else begin
            chk("busy", busy, 1'b1);
            chk("wr_en", mem_wr_en, 1'b1);
            if (sb.size() == 0) begin
               chk("sb_underflow", sb.size(), 1);
            end else begin
               e = sb[0];
               chk("addr", mem_addr, e.addr);
               chk("data", mem_wdata, e.data);
               if (mem_ready) begin
                  void'(sb.pop_front());
                  word++;
               end else begin
                  stalls++;
               end
            end
         end
         @(posedge clk); #1;
      end
      if (!seen) chk("done_timeout", write_done, 1'b1);
      mem_ready = 1'b1;
   endtask

   task automatic drop_done();
      cmd = 1'b0;
      @(negedge clk);
      chk("done_hold", write_done, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_fall", write_done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; cmd = 1'b0; mem_ready = 1'b1;
      c11 = '0; c12 = '0; c21 = '0; c22 = '0; base_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_en", mem_wr_en, 1'b0);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_wdata", mem_wdata, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_write_done", write_done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // basic burst with re-arm
      capture(8'h11, 8'h22, 8'h33, 8'h44, 8'h10);
      run_write(-1, 0, 1'b0, 5);
      drop_done();

      // three stall cycles on the second word
      capture(8'h11, 8'h22, 8'h33, 8'h44, 8'h10);
      run_write(1, 3, 1'b0, 8);
      drop_done();

      // address wrap
      capture(8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'hFE);
      run_write(-1, 0, 1'b0, 5);
      drop_done();

      // engine inputs change during the burst
      capture(8'h01, 8'h02, 8'h03, 8'h04, 8'h80);
      run_write(-1, 0, 1'b1, 5);
      drop_done();

      // reset in the middle of the burst
      capture(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h40);
      @(negedge clk);
      chk("rst_w0_addr", mem_addr, 8'h40);
      chk("rst_w0_data", mem_wdata, 8'hA1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_w1_addr", mem_addr, 8'h41);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_wr_en", mem_wr_en, 1'b0);
      chk("mid_rst_addr", mem_addr, 8'h00);
      chk("mid_rst_wdata", mem_wdata, 8'h00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", write_done, 1'b0);
      sb.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("held_done_no_wr", mem_wr_en, 1'b0);
         chk("held_done_no_done", write_done, 1'b0);
      end
      @(posedge clk); #1;
      cmd = 1'b0;
      @(posedge clk); #1;
      capture(8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h20);
      run_write(-1, 0, 1'b0, 5);
      drop_done();

      // second pulse after re-arm
      capture(8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h30);
      run_write(2, 1, 1'b0, 6);
      drop_done();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_custom_result_writer
